// File: rtl/counter_arbiter.sv
// Round-robin arbiter that shares one up/down counter among NREQ single-step requesters.
// Define COUNTER_ARB_SAT_EN to saturate at the bounds instead of wrapping.
module counter_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_i,
    input  logic [NREQ-1:0]  dir_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic             increment_o,
    output logic             decrement_o,
    output logic [WIDTH-1:0] shadow_o,
    output logic             stall_o
);

    localparam int PTR_W = $clog2(NREQ);

    logic [NREQ-1:0]  gnt_q;
    logic             increment_q;
    logic             decrement_q;
    logic [WIDTH-1:0] shadow_q;
    logic [PTR_W-1:0] last_ptr_q;
    logic [NREQ-1:0]  elig;
    logic             found;
    logic [PTR_W-1:0] win;

`ifdef COUNTER_ARB_SAT_EN
    localparam logic [WIDTH-1:0] SHADOW_MAX = {WIDTH{1'b1}};
    logic stall_q;

    // A step that would cross a bound is held back until the count moves away from it.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_i[i] & (dir_i[i] ? (shadow_q != SHADOW_MAX) : (shadow_q != '0));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= (|req_i) & ~found;
        end
    end

    assign stall_o = stall_q;
`else
    assign elig    = req_i;
    assign stall_o = 1'b0;
`endif

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && elig[PTR_W'((int'(last_ptr_q) + k) % NREQ)]) begin
                found = 1'b1;
                win   = PTR_W'((int'(last_ptr_q) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q       <= '0;
            increment_q <= 1'b0;
            decrement_q <= 1'b0;
            shadow_q    <= '0;
            last_ptr_q  <= PTR_W'(NREQ - 1);
        end else if (found) begin
            gnt_q       <= NREQ'(1) << win;
            increment_q <= dir_i[win];
            decrement_q <= ~dir_i[win];
            shadow_q    <= dir_i[win] ? shadow_q + WIDTH'(1) : shadow_q - WIDTH'(1);
            last_ptr_q  <= win;
        end else begin
            gnt_q       <= '0;
            increment_q <= 1'b0;
            decrement_q <= 1'b0;
        end
    end

    assign gnt_o       = gnt_q;
    assign increment_o = increment_q;
    assign decrement_o = decrement_q;
    assign shadow_o    = shadow_q;

endmodule
